// File: rtl/lsu_byte_master.sv
// lsu_byte_master: RV32I load/store initiator for the byte-wide,
// synchronous-read port A of the shared EBR memory. Each request is split
// into sequential little-endian byte accesses followed by one response.
// Optional feature: define LSU_RANGE_CHECK_EN to reject addresses with any
// of req_addr[31:MEM_AW] set; otherwise those bits are ignored and the
// address aliases modulo 2^MEM_AW.
module lsu_byte_master #(
  parameter int unsigned MEM_AW = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wd,
  input  logic [7:0]        mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t            state;
  logic              op_we;
  logic              op_signed;
  logic [1:0]        op_last;   // n-1: index of the final byte
  logic [MEM_AW-1:0] op_addr;
  logic [3:0][7:0]   op_wdata;
  logic [1:0]        k;
  logic [1:0]        k_next;
  logic [1:0]        k_prev;
  logic [3:0][7:0]   ld_buf;
  logic [3:0][7:0]   ld_final;
  logic [31:0]       ld_ext;

  logic              f3_ok;
  logic [1:0]        req_last;
  logic              misaligned;
  logic              range_err;
  logic              req_err;

  assign req_ready = (state == S_IDLE);
  assign k_next    = k + 2'd1;
  assign k_prev    = k - 2'd1;

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = |req_addr[31:MEM_AW];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_AW];
  assign range_err      = 1'b0;
`endif

  // Decode access size and legality of the presented request.
  always_comb begin
    f3_ok    = 1'b0;
    req_last = 2'd0;
    case (req_funct3)
      3'd0: begin f3_ok = 1'b1;    req_last = 2'd0; end
      3'd1: begin f3_ok = 1'b1;    req_last = 2'd1; end
      3'd2: begin f3_ok = 1'b1;    req_last = 2'd3; end
      3'd4: begin f3_ok = !req_we; req_last = 2'd0; end
      3'd5: begin f3_ok = !req_we; req_last = 2'd1; end
      default: begin f3_ok = 1'b0; req_last = 2'd0; end
    endcase
    misaligned = ((req_last == 2'd1) && req_addr[0]) ||
                 ((req_last == 2'd3) && (req_addr[1:0] != 2'd0));
    req_err    = !f3_ok || misaligned || range_err;
  end

  // Merge the final byte arriving during DRAIN and extend to 32 bits.
  always_comb begin
    ld_final          = ld_buf;
    ld_final[op_last] = mem_rd;
    case (op_last)
      2'd0:    ld_ext = {{24{op_signed & ld_final[0][7]}}, ld_final[0]};
      2'd1:    ld_ext = {{16{op_signed & ld_final[1][7]}}, ld_final[1], ld_final[0]};
      default: ld_ext = ld_final;
    endcase
  end

  // Request sequencer with registered memory-port and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_we      <= 1'b0;
      op_signed  <= 1'b0;
      op_last    <= 2'd0;
      op_addr    <= '0;
      op_wdata   <= '0;
      k          <= 2'd0;
      ld_buf     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_we     <= req_we;
            op_signed <= !req_funct3[2];
            op_last   <= req_last;
            op_addr   <= req_addr[MEM_AW-1:0];
            op_wdata  <= req_wdata;
            k         <= 2'd0;
            if (req_err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              // Byte 0 is issued straight from the request inputs so the
              // memory sees it in the first cycle after acceptance.
              state    <= S_ACCESS;
              mem_we   <= req_we;
              mem_addr <= req_addr[MEM_AW-1:0];
              mem_wd   <= req_we ? req_wdata[7:0] : 8'h00;
            end
          end
        end
        S_ACCESS: begin
          // Read data lags the address by one cycle: byte k-1 lands now.
          if (!op_we && (k != 2'd0)) begin
            ld_buf[k_prev] <= mem_rd;
          end
          if (k == op_last) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
            if (op_we) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= '0;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            k        <= k_next;
            mem_addr <= op_addr + MEM_AW'(k_next);
            mem_wd   <= op_we ? op_wdata[k_next] : 8'h00;
          end
        end
        S_DRAIN: begin
          ld_buf[op_last] <= mem_rd;
          state           <= S_RESP;
          resp_valid      <= 1'b1;
          resp_err        <= 1'b0;
          resp_rdata      <= ld_ext;
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Self-checking bench for lsu_byte_master: directed cases plus randomized
// requests checked against a byte-array reference model.
module tb_lsu_byte_master;
  localparam int unsigned MEM_AW   = 19;
  localparam int unsigned MEM_SIZE = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wd;
  logic [7:0]        mem_rd;

  int checks = 0;
  int errors = 0;

  lsu_byte_master #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Synchronous-read EBR port model.
  logic [7:0] ebr [MEM_SIZE];
  always @(posedge clk) begin
    if (mem_we) ebr[mem_addr] <= mem_wd;
    mem_rd <= ebr[mem_addr];
  end

  // Reference memory contents.
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Expected outcome of one request, from the access-size and extension rules.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, output logic err,
                                output int n, output int lat,
                                output logic [31:0] rd);
    logic legal;
    logic sgn;
    logic [31:0] v;
    legal = 1'b1; sgn = 1'b0; n = 1;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: begin n = 4; end
      3'd4: begin n = 1; legal = !we; end
      3'd5: begin n = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    err = !legal || ((addr % n) != 0);
`ifdef LSU_RANGE_CHECK_EN
    if ((addr >> MEM_AW) != 0) err = 1'b1;
`endif
    rd = 32'h0;
    if (err) lat = 1;
    else if (we) lat = n + 1;
    else begin
      lat = n + 2;
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_rd((addr + i) % MEM_SIZE)) << (8 * i));
      if (sgn && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input string tag, output logic [31:0] got_rd);
    logic exp_err, got, e;
    int n, exp_lat, lat, nw, exp_nw;
    logic [31:0] exp_rd, rd;
    logic [MEM_AW-1:0] ea;
    model(we, f3, addr, exp_err, n, exp_lat, exp_rd);
    exp_nw = (we && !exp_err) ? n : 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0; lat = 0; nw = 0; e = 1'b0; rd = 32'h0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (mem_we) begin
        ea = MEM_AW'((addr + nw) % MEM_SIZE);
        checks++;
        if (nw >= exp_nw || mem_addr !== ea || mem_wd !== wd[8*nw +: 8]) begin
          errors++;
          $display("FAIL %s write%0d: addr %h data %h, want addr %h data %h (expected %0d writes)",
                   tag, nw, mem_addr, mem_wd, ea, wd[8*nw +: 8], exp_nw);
        end
        nw++;
      end
      if (resp_valid) begin got = 1'b1; lat = c; e = resp_err; rd = resp_rdata; end
    end
    got_rd = rd;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no resp_valid within 20 cycles, want latency %0d", tag, exp_lat);
    end else begin
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
      checks++;
      if (e !== exp_err) begin errors++; $display("FAIL %s err: got %b want %b", tag, e, exp_err); end
      checks++;
      if (rd !== exp_rd) begin errors++; $display("FAIL %s rdata: got %h want %h", tag, rd, exp_rd); end
    end
    checks++;
    if (nw != exp_nw) begin errors++; $display("FAIL %s write count: got %0d want %0d", tag, nw, exp_nw); end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after resp: resp_valid %b req_ready %b, want 0 1", tag, resp_valid, req_ready);
    end
    if (we && !exp_err)
      for (int i = 0; i < n; i++) ref_mem[(addr + i) % MEM_SIZE] = wd[8*i +: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || mem_we !== 1'b0 ||
        resp_rdata !== 32'h0 || mem_addr !== '0 || mem_wd !== 8'h00) begin
      errors++;
      $display("FAIL reset: ready %b rv %b re %b we %b rd %h ma %h wd %h, want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_err, mem_we, resp_rdata, mem_addr, mem_wd);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] r;
    do_req(1'b1, 3'd2, 32'h100, 32'h11223344, "sw_100", r);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, "lw_100", r);
    checks++;
    if (r !== 32'h11223344) begin errors++; $display("FAIL lw_100 value: got %h want 11223344", r); end
    do_req(1'b1, 3'd0, 32'h200, 32'h00000080, "sb_200", r);
    do_req(1'b1, 3'd0, 32'h201, 32'h0000007F, "sb_201", r);
    do_req(1'b0, 3'd0, 32'h200, 32'h0, "lb_200", r);
    checks++;
    if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_200 value: got %h want ffffff80", r); end
    do_req(1'b0, 3'd4, 32'h200, 32'h0, "lbu_200", r);
    checks++;
    if (r !== 32'h00000080) begin errors++; $display("FAIL lbu_200 value: got %h want 00000080", r); end
    do_req(1'b0, 3'd1, 32'h200, 32'h0, "lh_200", r);
    checks++;
    if (r !== 32'h00007F80) begin errors++; $display("FAIL lh_200 value: got %h want 00007f80", r); end
    do_req(1'b1, 3'd1, 32'h201, 32'hDEAD, "sh_201_misaligned", r);
    do_req(1'b0, 3'd3, 32'h100, 32'h0, "load_f3_3", r);
    do_req(1'b1, 3'd4, 32'h100, 32'hCAFEF00D, "store_f3_4", r);
    do_req(1'b1, 3'd2, 32'h0, 32'hA5A5_5A5A, "sw_0", r);
    do_req(1'b0, 3'd2, 32'h00080000, 32'h0, "lw_range", r);
  endtask

  task automatic test_random();
    logic [31:0] a, r;
    logic we;
    logic [2:0] f3;
    for (int i = 0; i < 150; i++) begin
      a  = 32'h400 + $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) a[31:MEM_AW] = 13'($urandom_range(1, 8191));
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      do_req(we, f3, a, $urandom, "random", r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int seen;
    do_req(1'b1, 3'd2, 32'h300, 32'hAABBCCDD, "sw_300_pre", r);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h300; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== MEM_AW'(32'h301)) begin
      errors++; $display("FAIL mid byte1: we %b addr %h, want 1 00301", mem_we, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1 || mem_addr !== '0) begin
      errors++; $display("FAIL mid reset: we %b ready %b addr %h, want 0 1 0", mem_we, req_ready, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL aborted resp: got %0d resp_valid cycles want 0", seen); end
    ref_mem[32'h300] = 8'h44;
    do_req(1'b0, 3'd2, 32'h300, 32'h0, "lw_300_after_abort", r);
    checks++;
    if (r !== 32'hAABBCC44) begin errors++; $display("FAIL abort contents: got %h want aabbcc44", r); end
  endtask

  initial begin
    for (int unsigned i = 0; i < MEM_SIZE; i++) ebr[i] = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
